decode_reg: RTL and testbench
=============================

# decode_reg

Fetch-to-decode pipeline register for the single-issue MIPS datapath. It latches the instruction word and PC offered by the fetch stage and splits the held instruction into decode fields. It produces the 16-bit immediate and the sign/zero-extension select consumed directly by the immediate extender. A one-entry skid buffer keeps the instruction that synchronous instruction memory returns while decode is stalled.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, value of `id_pc_plus4` out of reset.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  pipeline clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `if_valid`  in  1  fetch offers `if_instr` and `if_pc` this cycle
- `if_instr`  in  32  fetched instruction word
- `if_pc`  in  32  PC of `if_instr`
- `if_ready`  out  1  decode can accept the fetch offer (`!skid_full`, combinational)
- `stall`  in  1  downstream hold request; decode register keeps its contents
- `flush`  in  1  kill the decode register and the skid buffer (branch or jump redirect)
- `id_valid`  out  1  decode register holds a live instruction
- `id_instr`  out  32  held instruction
- `id_pc_plus4`  out  32  held PC + 4, modulo 2^32
- `id_opcode`, `id_funct`  out  6 each  `[31:26]`, `[5:0]`
- `id_rs`, `id_rt`, `id_rd`, `id_shamt`  out  5 each  `[25:21]`, `[20:16]`, `[15:11]`, `[10:6]`
- `id_imm`  out  16  `[15:0]`, feeds the extender immediate input
- `id_sign_ext_imm`  out  1  1 = sign extend, 0 = zero extend; feeds the extender select
- `load_use_bubble`  out  1  a hazard bubble is being inserted this cycle (0 when the feature is compiled out)

## Operation
- Fetch accept: the offer is accepted when `if_valid && if_ready`.
- Skid states are EMPTY and FULL, with one 64-bit entry (instruction and PC).
- Priority order: `rst` > `flush` > `stall` > hazard bubble > advance.
- Flush:
  - `id_valid` goes to 0 and the skid goes to EMPTY.
  - The same-cycle fetch offer is dropped, even though `if_ready` was 1.
- Stall:
  - The decode register holds.
  - If the skid is EMPTY and an offer is accepted, the offer is written to the skid and the skid goes FULL.
  - If the skid is already FULL, `if_ready` is 0 and the skid holds.
- Advance (no stall, no bubble):
  - If the skid is FULL, the decode register loads the skid entry and the skid goes EMPTY. The fetch offer is not accepted, because `if_ready` was 0.
  - Else if an offer is accepted, the decode register loads the fetch input directly.
  - Else the decode register loads a bubble: `id_valid` = 0, fields hold their previous values.
- `id_sign_ext_imm` is decoded from the held opcode:
  - 0 for 6'h0C ANDI, 6'h0D ORI, 6'h0E XORI and 6'h0F LUI.
  - 1 for all other opcodes.
- Field outputs are pure slices of `id_instr`. They are valid only while `id_valid` is 1.

## Timing
- Latency: an accepted offer with no stall appears on the `id_*` outputs the cycle after acceptance.
- An instruction taken through the skid appears one cycle after the stall is released.
- Throughput: one instruction per cycle. After any stall that filled the skid, one fetch slot is lost (`if_ready` = 0 during the skid drain).
- Reset values: `id_valid` = 0, `id_instr` = 0, `id_pc_plus4` = `RESET_PC`, skid = EMPTY, `if_ready` = 1, `load_use_bubble` = 0. Derived fields follow from `id_instr` = 0, so `id_sign_ext_imm` = 1.
- Reset asserted mid-stall discards both the decode and skid contents immediately, without waiting for a clock edge.
- `flush` and `stall` asserted in the same cycle: flush wins.

## Configuration
- Macro: `DECODE_LOAD_USE_EN`.
- Defined:
  - A hazard exists when `id_valid` = 1, the held opcode is a load (6'h20–6'h25), `id_rt` != 0, and the next instruction (skid entry if FULL, else the accepted fetch offer) has rs or rt equal to `id_rt`.
  - On a hazard in an otherwise-advancing cycle, the decode register loads a bubble and `load_use_bubble` = 1.
  - The next instruction is kept: it stays in the skid, or is written to the skid if it came from fetch.
  - Result: exactly one bubble per load-use pair.
- Undefined: no hazard detection, no bubbles, and `load_use_bubble` is tied to 0.

## Test plan
- Reset, then offer `if_instr` = 32'h3C01_1234 (LUI), `if_pc` = 32'h0000_0040 -> next cycle `id_valid` = 1, `id_imm` = 16'h1234, `id_sign_ext_imm` = 0, `id_pc_plus4` = 32'h0000_0044.
- Offer ADDI 32'h2022_FFFF -> `id_sign_ext_imm` = 1, `id_rs` = 1, `id_rt` = 2, `id_imm` = 16'hFFFF.
- Stall 3 cycles while fetch offers instruction B:
  - B captured in the skid, then `if_ready` = 0 and `id_*` held.
  - On release, B appears in decode the next cycle and `if_ready` returns to 1.
- Flush with skid FULL and `stall` = 1 -> next cycle `id_valid` = 0, `if_ready` = 1, and the next offer loads normally.
- Offer PC = 32'hFFFF_FFFC -> `id_pc_plus4` = 32'h0000_0000.
- With `DECODE_LOAD_USE_EN`: LW $3 (32'h8C03_0000) followed by ADD $4,$3,$5 -> one cycle with `id_valid` = 0 and `load_use_bubble` = 1, then the ADD in decode. ADD $4,$6,$5 after the load -> no bubble.

Source files
------------

// File: rtl/decode_reg.sv
// Fetch-to-decode pipeline register with a one-entry skid buffer and field split.
// Optional load-use bubble insertion is enabled with the DECODE_LOAD_USE_EN macro.
module decode_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic        if_ready,
    input  logic        stall,
    input  logic        flush,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic [5:0]  id_opcode,
    output logic [5:0]  id_funct,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    output logic [4:0]  id_shamt,
    output logic [15:0] id_imm,
    output logic        id_sign_ext_imm,
    output logic        load_use_bubble
);

    typedef enum logic {
        SKID_EMPTY,
        SKID_FULL
    } skid_state_e;

    skid_state_e skidState_q, skidState_d;
    logic [31:0] skidInstr_q, skidInstr_d;
    logic [31:0] skidPc_q, skidPc_d;
    logic        idValid_q, idValid_d;
    logic [31:0] idInstr_q, idInstr_d;
    logic [31:0] idPcPlus4_q, idPcPlus4_d;
    logic        accept;
    logic        hazard;

    assign if_ready = (skidState_q == SKID_EMPTY);
    assign accept   = if_valid && if_ready;

`ifdef DECODE_LOAD_USE_EN
    logic [31:0] nextInstr;
    logic        nextAvail;
    logic        heldIsLoad;

    // The instruction that would enter decode next: skid has priority over fetch.
    assign nextInstr  = (skidState_q == SKID_FULL) ? skidInstr_q : if_instr;
    assign nextAvail  = (skidState_q == SKID_FULL) || accept;
    assign heldIsLoad = (idInstr_q[31:26] >= 6'h20) && (idInstr_q[31:26] <= 6'h25);
    assign hazard     = idValid_q && heldIsLoad && (idInstr_q[20:16] != 5'd0) && nextAvail &&
                        ((nextInstr[25:21] == idInstr_q[20:16]) ||
                         (nextInstr[20:16] == idInstr_q[20:16]));
`else
    assign hazard = 1'b0;
`endif

    always_comb begin
        skidState_d     = skidState_q;
        skidInstr_d     = skidInstr_q;
        skidPc_d        = skidPc_q;
        idValid_d       = idValid_q;
        idInstr_d       = idInstr_q;
        idPcPlus4_d     = idPcPlus4_q;
        load_use_bubble = 1'b0;

        if (flush) begin
            idValid_d   = 1'b0;
            skidState_d = SKID_EMPTY;
        end else if (stall) begin
            if (accept) begin
                skidInstr_d = if_instr;
                skidPc_d    = if_pc;
                skidState_d = SKID_FULL;
            end
        end else if (hazard) begin
            // Bubble decode but keep the dependent instruction for the next cycle.
            idValid_d       = 1'b0;
            load_use_bubble = 1'b1;
            if (accept) begin
                skidInstr_d = if_instr;
                skidPc_d    = if_pc;
                skidState_d = SKID_FULL;
            end
        end else if (skidState_q == SKID_FULL) begin
            idValid_d   = 1'b1;
            idInstr_d   = skidInstr_q;
            idPcPlus4_d = skidPc_q + 32'd4;
            skidState_d = SKID_EMPTY;
        end else if (accept) begin
            idValid_d   = 1'b1;
            idInstr_d   = if_instr;
            idPcPlus4_d = if_pc + 32'd4;
        end else begin
            idValid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skidState_q <= SKID_EMPTY;
            skidInstr_q <= 32'd0;
            skidPc_q    <= 32'd0;
            idValid_q   <= 1'b0;
            idInstr_q   <= 32'd0;
            idPcPlus4_q <= RESET_PC;
        end else begin
            skidState_q <= skidState_d;
            skidInstr_q <= skidInstr_d;
            skidPc_q    <= skidPc_d;
            idValid_q   <= idValid_d;
            idInstr_q   <= idInstr_d;
            idPcPlus4_q <= idPcPlus4_d;
        end
    end

    assign id_valid    = idValid_q;
    assign id_instr    = idInstr_q;
    assign id_pc_plus4 = idPcPlus4_q;
    assign id_opcode   = idInstr_q[31:26];
    assign id_rs       = idInstr_q[25:21];
    assign id_rt       = idInstr_q[20:16];
    assign id_rd       = idInstr_q[15:11];
    assign id_shamt    = idInstr_q[10:6];
    assign id_funct    = idInstr_q[5:0];
    assign id_imm      = idInstr_q[15:0];

    // Logical immediates (ANDI/ORI/XORI/LUI, opcodes 0x0C-0x0F) are zero extended.
    assign id_sign_ext_imm = (idInstr_q[31:28] != 4'b0011);

endmodule

// File: tb/tb_decode_reg.sv
// Directed self-checking bench for decode_reg.
// Load-use expectations depend on whether DECODE_LOAD_USE_EN is defined.
module tb_decode_reg;

    logic        clk;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        stall;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc_plus4;
    logic [5:0]  id_opcode;
    logic [5:0]  id_funct;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  id_rd;
    logic [4:0]  id_shamt;
    logic [15:0] id_imm;
    logic        id_sign_ext_imm;
    logic        load_use_bubble;

    int checks;
    int failures;

    decode_reg #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .if_valid        (if_valid),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_ready        (if_ready),
        .stall           (stall),
        .flush           (flush),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc_plus4     (id_pc_plus4),
        .id_opcode       (id_opcode),
        .id_funct        (id_funct),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_shamt        (id_shamt),
        .id_imm          (id_imm),
        .id_sign_ext_imm (id_sign_ext_imm),
        .load_use_bubble (load_use_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                                 input logic st, input logic fl);
        if_valid = v;
        if_instr = instr;
        if_pc    = pc;
        stall    = st;
        flush    = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        #2;
        checkOutput("rst_valid", {31'd0, id_valid}, 32'd0);
        checkOutput("rst_instr", id_instr, 32'd0);
        checkOutput("rst_pc4", id_pc_plus4, 32'd0);
        checkOutput("rst_ready", {31'd0, if_ready}, 32'd1);
        checkOutput("rst_sext", {31'd0, id_sign_ext_imm}, 32'd1);
        checkOutput("rst_bubble", {31'd0, load_use_bubble}, 32'd0);
        tick();
        rst = 1'b0;

        // LUI $1,0x1234 at PC 0x40
        applyStimulus(1'b1, 32'h3C01_1234, 32'h0000_0040, 1'b0, 1'b0);
        tick();
        checkOutput("lui_valid", {31'd0, id_valid}, 32'd1);
        checkOutput("lui_imm", {16'd0, id_imm}, 32'h1234);
        checkOutput("lui_sext", {31'd0, id_sign_ext_imm}, 32'd0);
        checkOutput("lui_pc4", id_pc_plus4, 32'h0000_0044);
        checkOutput("lui_op", {26'd0, id_opcode}, 32'h0F);
        checkOutput("lui_rt", {27'd0, id_rt}, 32'd1);

        // ADDI $2,$1,-1
        applyStimulus(1'b1, 32'h2022_FFFF, 32'h0000_0044, 1'b0, 1'b0);
        tick();
        checkOutput("addi_sext", {31'd0, id_sign_ext_imm}, 32'd1);
        checkOutput("addi_rs", {27'd0, id_rs}, 32'd1);
        checkOutput("addi_rt", {27'd0, id_rt}, 32'd2);
        checkOutput("addi_imm", {16'd0, id_imm}, 32'hFFFF);
        checkOutput("addi_pc4", id_pc_plus4, 32'h0000_0048);

        // Stall 3 cycles while fetch offers ADD $7,$5,$6 (0x00A63820)
        applyStimulus(1'b1, 32'h00A6_3820, 32'h0000_0048, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("stall%0d_ready", i), {31'd0, if_ready}, 32'd0);
            checkOutput($sformatf("stall%0d_instr", i), id_instr, 32'h2022_FFFF);
            checkOutput($sformatf("stall%0d_valid", i), {31'd0, id_valid}, 32'd1);
        end
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkOutput("drain_instr", id_instr, 32'h00A6_3820);
        checkOutput("drain_pc4", id_pc_plus4, 32'h0000_004C);
        checkOutput("drain_valid", {31'd0, id_valid}, 32'd1);
        checkOutput("drain_ready", {31'd0, if_ready}, 32'd1);
        checkOutput("drain_rd", {27'd0, id_rd}, 32'd7);
        checkOutput("drain_funct", {26'd0, id_funct}, 32'h20);

        // Fill the skid, then flush while still stalled
        applyStimulus(1'b1, 32'h1111_1111, 32'h0000_0050, 1'b1, 1'b0);
        tick();
        checkOutput("fill_ready", {31'd0, if_ready}, 32'd0);
        applyStimulus(1'b1, 32'h2222_2222, 32'h0000_0054, 1'b1, 1'b1);
        tick();
        checkOutput("flush_valid", {31'd0, id_valid}, 32'd0);
        checkOutput("flush_ready", {31'd0, if_ready}, 32'd1);

        // ORI $2,$0,0xABCD at the top of the address space
        applyStimulus(1'b1, 32'h3402_ABCD, 32'hFFFF_FFFC, 1'b0, 1'b0);
        tick();
        checkOutput("wrap_valid", {31'd0, id_valid}, 32'd1);
        checkOutput("wrap_instr", id_instr, 32'h3402_ABCD);
        checkOutput("wrap_pc4", id_pc_plus4, 32'h0000_0000);
        checkOutput("wrap_sext", {31'd0, id_sign_ext_imm}, 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
        checkOutput("idle_valid", {31'd0, id_valid}, 32'd0);
        checkOutput("idle_imm", {16'd0, id_imm}, 32'hABCD);

        // LW $3,0($0) followed by ADD $4,$3,$5 (dependent)
        applyStimulus(1'b1, 32'h8C03_0000, 32'h0000_0100, 1'b0, 1'b0);
        tick();
        checkOutput("lw_instr", id_instr, 32'h8C03_0000);
        applyStimulus(1'b1, 32'h0065_2020, 32'h0000_0104, 1'b0, 1'b0);
        #1;
`ifdef DECODE_LOAD_USE_EN
        checkOutput("lu_bubble", {31'd0, load_use_bubble}, 32'd1);
        tick();
        checkOutput("lu_valid", {31'd0, id_valid}, 32'd0);
        checkOutput("lu_ready", {31'd0, if_ready}, 32'd0);
        checkOutput("lu_bubble_off", {31'd0, load_use_bubble}, 32'd0);
        applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        tick();
`else
        checkOutput("lu_bubble", {31'd0, load_use_bubble}, 32'd0);
        tick();
`endif
        checkOutput("lu_add_instr", id_instr, 32'h0065_2020);
        checkOutput("lu_add_valid", {31'd0, id_valid}, 32'd1);
        checkOutput("lu_add_pc4", id_pc_plus4, 32'h0000_0108);

        // LW $3 followed by independent ADD $4,$6,$5
        applyStimulus(1'b1, 32'h8C03_0000, 32'h0000_0200, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 32'h00C5_2020, 32'h0000_0204, 1'b0, 1'b0);
        #1;
        checkOutput("nodep_bubble", {31'd0, load_use_bubble}, 32'd0);
        tick();
        checkOutput("nodep_instr", id_instr, 32'h00C5_2020);
        checkOutput("nodep_valid", {31'd0, id_valid}, 32'd1);

        // Asynchronous reset in the middle of a stall with the skid full
        applyStimulus(1'b1, 32'h3333_3333, 32'h0000_0300, 1'b1, 1'b0);
        tick();
        checkOutput("pre_rst_ready", {31'd0, if_ready}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_valid", {31'd0, id_valid}, 32'd0);
        checkOutput("async_rst_ready", {31'd0, if_ready}, 32'd1);
        checkOutput("async_rst_instr", id_instr, 32'd0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
